// File: rtl/gpio_serial_loader.sv
// Sequencer that walks the user-pad configuration words from pad N-1 down to 0,
// shifts each MSB-first into the GPIO control daisy chain and then latches it.
module gpio_serial_loader #(
    parameter int  MPRJ_IO_PADS = 38,
    parameter int  CFG_BITS     = 13,
    parameter int  CLK_DIV      = 2,
    localparam int IDX_W        = (MPRJ_IO_PADS > 1) ? $clog2(MPRJ_IO_PADS) : 1
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                xfer,
    output logic [IDX_W-1:0]    cfg_idx,
    input  logic [CFG_BITS-1:0] cfg_word,
    output logic                busy,
    output logic                done,
    output logic                serial_clock,
    output logic                serial_load,
    output logic                serial_resetn,
    output logic                serial_data_out
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [CFG_BITS-1:0] shreg_q, shreg_d;
    logic                sdo_q, sdo_d;
    logic                sclk_q, sclk_d;
    logic                load_q, load_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                srstn_q;
    logic                phase_end;

    assign phase_end = (div_q == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            shreg_q <= '0;
            sdo_q   <= 1'b0;
            sclk_q  <= 1'b0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            srstn_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            shreg_q <= shreg_d;
            sdo_q   <= sdo_d;
            sclk_q  <= sclk_d;
            load_q  <= load_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            srstn_q <= 1'b1;
        end
    end

    // Every output register is loaded on the edge that enters the state it
    // belongs to, so data and clock/strobe levels always change together.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        div_d   = div_q;
        shreg_d = shreg_q;
        sdo_d   = sdo_q;
        sclk_d  = sclk_q;
        load_d  = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    state_d = S_FETCH;
                    idx_d   = IDX_W'(MPRJ_IO_PADS - 1);
                    busy_d  = 1'b1;
                    sclk_d  = 1'b0;
                end
            end
            S_FETCH: begin
                shreg_d = cfg_word;
                sdo_d   = cfg_word[CFG_BITS-1];
                bit_d   = BIT_W'(CFG_BITS - 1);
                div_d   = '0;
                sclk_d  = 1'b0;
                state_d = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (phase_end) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = S_SHIFT_HI;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_SHIFT_HI: begin
                if (phase_end) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q != '0) begin
                        bit_d   = bit_q - BIT_W'(1);
                        shreg_d = shreg_q << 1;
                        sdo_d   = shreg_d[CFG_BITS-1];
                        state_d = S_SHIFT_LO;
                    end else if (idx_q != '0) begin
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = S_FETCH;
                    end else begin
                        load_d  = 1'b1;
                        state_d = S_LATCH;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_LATCH: begin
                if (phase_end) begin
                    div_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    load_d = 1'b1;
                    div_d  = div_q + DIV_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cfg_idx         = idx_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign serial_clock    = sclk_q;
    assign serial_load     = load_q;
    assign serial_resetn   = srstn_q;
    assign serial_data_out = sdo_q;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Three loader instances (2x4 div1, 2x4 div3, 38x13 div2) driven with random
// words; a chain model and cycle-position rules supply all expected values.
module tb_gpio_serial_loader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int n_fin    = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int PADS = (g == 2) ? 38 : 2;
        localparam int BITS = (g == 2) ? 13 : 4;
        localparam int DIV  = (g == 0) ? 1 : (g == 1) ? 3 : 2;
        localparam int IW   = $clog2(PADS);
        localparam int PER  = 1 + 2 * DIV * BITS;
        localparam int N    = PADS * PER + DIV + 1;

        logic            resetn, xfer, busy, done, sclk, sload, srstn, sdo;
        logic [IW-1:0]   idx;
        logic [BITS-1:0] word;
        logic [BITS-1:0] words [PADS];

        gpio_serial_loader #(
            .MPRJ_IO_PADS(PADS), .CFG_BITS(BITS), .CLK_DIV(DIV)
        ) u_dut (
            .clock(clock), .resetn(resetn), .xfer(xfer), .cfg_idx(idx),
            .cfg_word(word), .busy(busy), .done(done), .serial_clock(sclk),
            .serial_load(sload), .serial_resetn(srstn), .serial_data_out(sdo)
        );

        function automatic string t(input string s);
            return $sformatf("c%0d/%s", g, s);
        endfunction

        // cycle k = interval after the k-th edge following the xfer-sampling edge
        function automatic bit exp_sclk(input int k);
            int o;
            if (k < 1 || k > PADS * PER) return 1'b0;
            o = (k - 1) % PER;
            if (o == 0) return 1'b0;
            return ((o - 1) % (2 * DIV)) >= DIV;
        endfunction

        task automatic fill_words();
            for (int p = 0; p < PADS; p++) words[p] = BITS'($urandom);
        endtask

        task automatic run(input string tag, input bit hold, input bit repulse, input int rst_at);
            bit q[$];
            int done_k, n_done, n_load, load_cyc, bad_inv, bad_clk, bad_busy, bad_idx, last, w;
            bit psclk, psdo, pload;
            done_k = 0; n_done = 0; n_load = 0; load_cyc = 0;
            bad_inv = 0; bad_clk = 0; bad_busy = 0; bad_idx = 0;
            psclk = 1'b0; pload = 1'b0; psdo = sdo;
            last = (rst_at > 0) ? rst_at : N + 2;
            @(negedge clock); xfer = 1'b1;
            @(posedge clock);
            for (int k = 1; k <= last; k++) begin
                #1;
                xfer = hold || (repulse && (k == 5 || k == 10));
                if (k <= PADS * PER && (k - 1) % PER == 0) begin
                    if (idx != IW'(PADS - 1 - (k - 1) / PER)) bad_idx++;
                    word = words[idx];
                end else begin
                    word = BITS'($urandom);
                end
                @(negedge clock);
                if (sclk && !psclk) q.push_back(sdo);
                if (sdo != psdo && sclk) bad_inv++;
                if (sload && sclk) bad_inv++;
                if (sload) load_cyc++;
                if (sload && !pload) n_load++;
                if (done) begin n_done++; done_k = k; end
                if (sclk != exp_sclk(k)) bad_clk++;
                if (busy != ((k < N) || (hold && k == N + 2))) bad_busy++;
                psclk = sclk; psdo = sdo; pload = sload;
                if (k == rst_at) begin
                    #2 resetn = 1'b0;
                    #1;
                    chk(t({tag, "/async_drop"}),
                        int'({sclk, sload, busy, srstn, done, sdo}), 0);
                    chk(t({tag, "/idx_rst"}), int'(idx), 0);
                    repeat (3) begin
                        @(negedge clock);
                        if (sload) n_load++;
                        if (done) n_done++;
                    end
                    resetn = 1'b1;
                    @(posedge clock); #1;
                    chk(t({tag, "/srstn_back"}), int'(srstn), 1);
                end
                @(posedge clock);
            end
            xfer = 1'b0;
            chk(t({tag, "/inv"}), bad_inv, 0);
            chk(t({tag, "/sclk_timing"}), bad_clk, 0);
            chk(t({tag, "/busy"}), bad_busy, 0);
            chk(t({tag, "/cfg_idx"}), bad_idx, 0);
            if (rst_at > 0) begin
                chk(t({tag, "/no_done"}), n_done, 0);
                chk(t({tag, "/no_load"}), n_load, 0);
            end else begin
                chk(t({tag, "/done_cycle"}), done_k, N);
                chk(t({tag, "/done_count"}), n_done, 1);
                chk(t({tag, "/load_pulses"}), n_load, 1);
                chk(t({tag, "/load_cycles"}), load_cyc, DIV);
                chk(t({tag, "/nbits"}), q.size(), PADS * BITS);
                if (q.size() == PADS * BITS) begin
                    for (int p = 0; p < PADS; p++) begin
                        w = 0;
                        for (int j = 0; j < BITS; j++)
                            w = (w << 1) | int'(q[(PADS - 1 - p) * BITS + j]);
                        chk(t($sformatf("%s/pad%0d", tag, p)), w, int'(words[p]));
                    end
                end
            end
        endtask

        task automatic do_reset();
            #2 resetn = 1'b0;
            #1 chk(t("busy_cleared"), int'(busy), 0);
            @(negedge clock); resetn = 1'b1;
            @(posedge clock); #1;
        endtask

        initial begin
            int bad;
            resetn = 1'b1; xfer = 1'b0; word = '0;
            #1 resetn = 1'b0;
            #1;
            chk(t("reset_outs"), int'({busy, done, sclk, sload, srstn, sdo}), 0);
            chk(t("reset_idx"), int'(idx), 0);
            repeat (2) @(posedge clock);
            @(negedge clock); resetn = 1'b1;
            #1 chk(t("srstn_before_edge"), int'(srstn), 0);
            @(posedge clock); #1;
            chk(t("srstn_after_edge"), int'(srstn), 1);
            bad = 0;
            repeat (3) begin
                @(negedge clock);
                if (busy || done || sclk || sload) bad++;
            end
            chk(t("idle_quiet"), bad, 0);

            fill_words();
            if (PADS == 2 && BITS == 4) begin
                words[1] = BITS'(10);
                words[0] = BITS'(3);
            end
            run("base", 1'b0, 1'b0, 0);
            fill_words(); run("repulse", 1'b0, 1'b1, 0);
            fill_words(); run("hold", 1'b1, 1'b0, 0);
            do_reset();
            fill_words(); run("rst8", 1'b0, 1'b0, 8);
            fill_words(); run("after", 1'b0, 1'b0, 0);
            n_fin++;
        end
    end

    initial begin
        fork
            wait (n_fin == 3);
            #500_000;
        join_any
        if (n_fin != 3) chk("timeout", n_fin, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_serial_loader.md
Name: gpio_serial_loader

Overview:
- Management-domain sequencer that programs the per-pad user GPIO configuration chain.
- Takes one configuration word per user pad from housekeeping registers and shifts it serially into the daisy-chained GPIO control blocks.
- Pulses the chain load strobe so the blocks update the mprj_io_* control buses consumed by the padframe.
- Sits directly upstream of the padframe controls.

Parameters:
- MPRJ_IO_PADS, 38, number of user pads in the chain.
- CFG_BITS, 13, configuration bits per pad.
- CLK_DIV, 2, clock cycles per serial_clock half-period (>=1).

Ports:
- clock  input  1  management core clock.
- resetn  input  1  asynchronous active-low reset.
- xfer  input  1  start request; sampled only in IDLE.
- cfg_idx  output  $clog2(MPRJ_IO_PADS)  pad index whose word is requested.
- cfg_word  input  CFG_BITS  configuration word for cfg_idx; combinational from the register file, valid in the same cycle.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse at transfer completion.
- serial_clock  output  1  chain shift clock.
- serial_load  output  1  chain latch strobe.
- serial_resetn  output  1  chain reset, active low.
- serial_data_out  output  1  chain serial data.

Behaviour:
- Reset is asynchronous, active-low, fixed.
- Reset values: busy=0, done=0, serial_clock=0, serial_load=0, serial_resetn=0, serial_data_out=0, cfg_idx=0, state=IDLE.
- serial_resetn is a register: 0 under reset, 1 from the first clock edge after resetn deasserts, then stays 1.
- All outputs are registered. No combinational path from xfer or cfg_word to any output.
- States: IDLE, FETCH, SHIFT_LO, SHIFT_HI, LATCH, DONE.
- IDLE:
  - xfer=1 at an edge -> FETCH.
  - cfg_idx<=MPRJ_IO_PADS-1.
  - busy<=1.
- FETCH (1 cycle):
  - cfg_word captured into shift register.
  - bit counter <= CFG_BITS-1.
  - -> SHIFT_LO.
- SHIFT_LO (CLK_DIV cycles):
  - serial_clock=0.
  - serial_data_out = current bit, driven from the first SHIFT_LO cycle.
  - -> SHIFT_HI.
- SHIFT_HI (CLK_DIV cycles):
  - serial_clock=1.
  - serial_data_out held stable (chain samples on the rising edge).
  - At the end, if bit counter > 0: decrement, -> SHIFT_LO.
  - Else if cfg_idx > 0: cfg_idx decrements, -> FETCH.
  - Else -> LATCH.
- Shift order:
  - Pad MPRJ_IO_PADS-1 first (farthest in chain), pad 0 last.
  - Within a word, MSB first.
- LATCH (CLK_DIV cycles):
  - serial_clock=0, serial_load=1.
  - -> DONE.
- DONE (1 cycle):
  - serial_load=0, done=1, busy=0.
  - -> IDLE.
- Cycle count from the xfer-sampling edge to the done pulse = MPRJ_IO_PADS*(1+2*CLK_DIV*CFG_BITS) + CLK_DIV + 1.
- Boundary conditions:
  - xfer while busy: ignored; no queueing.
  - xfer held high through DONE: a new transfer starts on the first IDLE edge.
  - resetn asserted mid-transfer: immediate return to reset values. serial_load must not pulse. Chain contents are undefined until the next full transfer.
  - serial_load and serial_clock are never high in the same cycle.
  - serial_data_out changes only while serial_clock=0.
  - cfg_word is sampled only in FETCH. Changes at any other time have no effect.

Test Plan:
- Reset release -> all outputs 0 under reset; serial_resetn=1 one edge after resetn rises; busy stays 0 with xfer=0.
- MPRJ_IO_PADS=2, CFG_BITS=4, CLK_DIV=1, words pad1=4'b1010, pad0=4'b0011, pulse xfer -> serial_data_out at the serial_clock rising edges reads 1,0,1,0,0,0,1,1; serial_load high for exactly 1 cycle; done pulses 20 cycles after the xfer edge; busy falls with done.
- Same config with CLK_DIV=3 -> each serial_clock phase lasts 3 cycles; done at cycle 2*(1+24)+3+1=54; bit sequence identical.
- xfer re-pulsed at cycles 5 and 10 of a transfer -> ignored; exactly one done pulse and one serial_load pulse.
- resetn asserted at cycle 8 of a transfer -> serial_clock, serial_load, busy and serial_resetn drop asynchronously; no done pulse; a fresh xfer afterwards completes normally.
- Default parameters (38 pads, 13 bits, CLK_DIV=2), random words -> a chain model receives all 38 words correctly after serial_load; done at cycle 38*53+3=2017.
